// File: rtl/mac_relu_unit.sv
// Two-stage signed multiply-accumulate with a combinational ReLU on the running sum.
// Stage 1 registers the product with a valid bit; stage 2 folds it into the accumulator.
module mac_relu_unit #(
    parameter int OP_W  = 16,
    parameter int ACC_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [OP_W-1:0]  a,
    input  logic signed [OP_W-1:0]  b,
    output logic signed [ACC_W-1:0] acc,
    output logic signed [ACC_W-1:0] relu_out
);

    logic signed [2*OP_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_fit;
    logic signed [ACC_W-1:0]  p1;
    logic                     v1;

    // Sized casts of signed values sign-extend or truncate to fit the accumulator.
    assign prod     = (2*OP_W)'(a) * (2*OP_W)'(b);
    assign prod_fit = ACC_W'(prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1  <= '0;
            v1  <= 1'b0;
            acc <= '0;
        end else if (clr) begin
            v1  <= 1'b0;
            acc <= '0;
        end else begin
            v1 <= en;
            if (en) begin
                p1 <= prod_fit;
            end
            if (v1) begin
                acc <= acc + p1;
            end
        end
    end

    assign relu_out = acc[ACC_W-1] ? '0 : acc;

endmodule

// File: tb/tb_mac_relu_unit.sv
// Bench for mac_relu_unit: a vector table replayed cycle by cycle through a scoreboard
// queue, plus hand-written sequences for asynchronous reset in the middle of a sum.
module tb_mac_relu_unit;

    localparam int OP_W  = 16;
    localparam int ACC_W = 32;

    logic                    clk;
    logic                    rst_n;
    logic                    clr;
    logic                    en;
    logic signed [OP_W-1:0]  a;
    logic signed [OP_W-1:0]  b;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] relu_out;

    int total;
    int bad;

    typedef struct {
        logic  clr;
        logic  en;
        int    a;
        int    b;
        logic  chk;
        int    exp_acc;
        string name;
    } vec_t;

    typedef struct {
        int    exp_acc;
        int    exp_relu;
        string name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    mac_relu_unit #(
        .OP_W (OP_W),
        .ACC_W(ACC_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .en      (en),
        .a       (a),
        .b       (b),
        .acc     (acc),
        .relu_out(relu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int relu_of(int v);
        return (v < 0) ? 0 : v;
    endfunction

    task automatic check_output(string name, int exp_acc, int exp_relu);
        total++;
        if (acc !== exp_acc) begin
            bad++;
            $display("[TB] FAIL %s acc: got %0d want %0d", name, acc, exp_acc);
        end
        total++;
        if (relu_out !== exp_relu) begin
            bad++;
            $display("[TB] FAIL %s relu_out: got %0d want %0d", name, relu_out, exp_relu);
        end
    endtask

    task automatic add_vec(logic c, logic e, int va, int vb, logic chk, int exp_acc, string name);
        vec_t v;
        v.clr     = c;
        v.en      = e;
        v.a       = va;
        v.b       = vb;
        v.chk     = chk;
        v.exp_acc = exp_acc;
        v.name    = name;
        vecs.push_back(v);
    endtask

    // Drive one vector for one cycle; its expectation describes acc just after that edge.
    task automatic apply_stimulus(vec_t v);
        exp_t e;
        @(negedge clk);
        clr = v.clr;
        en  = v.en;
        a   = OP_W'(v.a);
        b   = OP_W'(v.b);
        if (v.chk) begin
            e.exp_acc  = v.exp_acc;
            e.exp_relu = relu_of(v.exp_acc);
            e.name     = v.name;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (v.chk) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL %s scoreboard: got empty queue want 1 entry", v.name);
            end else begin
                e = sb.pop_front();
                check_output(e.name, e.exp_acc, e.exp_relu);
            end
        end
    endtask

    task automatic idle_cycle(logic chk, int exp_acc, string name);
        vec_t v;
        v.clr = 0; v.en = 0; v.a = 0; v.b = 0;
        v.chk = chk; v.exp_acc = exp_acc; v.name = name;
        apply_stimulus(v);
    endtask

    task automatic pair_cycle(int va, int vb, logic chk, int exp_acc, string name);
        vec_t v;
        v.clr = 0; v.en = 1; v.a = va; v.b = vb;
        v.chk = chk; v.exp_acc = exp_acc; v.name = name;
        apply_stimulus(v);
    endtask

    task automatic clr_cycle(logic chk, string name);
        vec_t v;
        v.clr = 1; v.en = 0; v.a = 0; v.b = 0;
        v.chk = chk; v.exp_acc = 0; v.name = name;
        apply_stimulus(v);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        clr   = 1'b0;
        en    = 1'b0;
        a     = '0;
        b     = '0;

        // Positive edge kernel: the ninth product lands one edge after its sample.
        add_vec(1, 0,  0,  0, 0,   0, "pos_clr");
        add_vec(0, 1, 10, -1, 0,   0, "pos_p1");
        add_vec(0, 1, 10, -1, 0, -10, "pos_p2");
        add_vec(0, 1, 10, -1, 1, -20, "pos_p3");
        add_vec(0, 1,  0,  0, 0, -30, "pos_p4");
        add_vec(0, 1,  0,  0, 0, -30, "pos_p5");
        add_vec(0, 1,  0,  0, 0, -30, "pos_p6");
        add_vec(0, 1, 20,  1, 0, -30, "pos_p7");
        add_vec(0, 1, 20,  1, 0, -10, "pos_p8");
        add_vec(0, 1, 20,  1, 1,  10, "pos_p9");
        add_vec(0, 0,  0,  0, 1,  30, "pos_final");
        add_vec(0, 0,  0,  0, 1,  30, "pos_hold1");
        add_vec(0, 0,  0,  0, 1,  30, "pos_hold2");
        // Negative edge kernel.
        add_vec(1, 0,  0,  0, 1,   0, "neg_clr");
        add_vec(0, 1, 20, -1, 0,   0, "neg_p1");
        add_vec(0, 1, 20, -1, 0, -20, "neg_p2");
        add_vec(0, 1, 20, -1, 0, -40, "neg_p3");
        add_vec(0, 1,  0,  0, 0, -60, "neg_p4");
        add_vec(0, 1,  0,  0, 0, -60, "neg_p5");
        add_vec(0, 1,  0,  0, 0, -60, "neg_p6");
        add_vec(0, 1, 10,  1, 0, -60, "neg_p7");
        add_vec(0, 1, 10,  1, 0, -50, "neg_p8");
        add_vec(0, 1, 10,  1, 0, -40, "neg_p9");
        add_vec(0, 0,  0,  0, 1, -30, "neg_final");
        add_vec(0, 0,  0,  0, 1, -30, "neg_hold");
        // Enable gaps, then clear colliding with a valid pair.
        add_vec(1, 0,  0,  0, 0,   0, "gap_clr");
        add_vec(0, 1,  3,  4, 0,   0, "gap_p1");
        add_vec(0, 0,  0,  0, 1,  12, "gap_first");
        add_vec(0, 0,  0,  0, 1,  12, "gap_hold");
        add_vec(0, 1,  5, -2, 0,  12, "gap_p2");
        add_vec(0, 0,  0,  0, 1,   2, "gap_sum");
        add_vec(0, 0,  0,  0, 1,   2, "gap_sum_hold");
        add_vec(1, 1,  7,  7, 1,   0, "clr_en_same");
        add_vec(0, 0,  0,  0, 1,   0, "clr_drop1");
        add_vec(0, 0,  0,  0, 1,   0, "clr_drop2");
        // Clear while a product is in flight.
        add_vec(0, 1,  9,  9, 1,   0, "inflight_p");
        add_vec(1, 0,  0,  0, 1,   0, "inflight_clr");
        add_vec(0, 0,  0,  0, 1,   0, "inflight_gone");
        // Overflow wraps.
        add_vec(1, 0,      0,      0, 0, 0,           "wrap_clr");
        add_vec(0, 1,  32767,  32767, 0, 0,           "wrap_p1");
        add_vec(0, 1,  32767,  32767, 1, 1073676289,  "wrap_1");
        add_vec(0, 1,  32767,  32767, 1, 2147352578,  "wrap_2");
        add_vec(0, 0,      0,      0, 1, -1073938429, "wrap_3");
        add_vec(0, 0,      0,      0, 1, -1073938429, "wrap_hold");
        // Most negative operands.
        add_vec(1, 0,      0,      0, 0, 0,           "ext_clr");
        add_vec(0, 1, -32768, -32768, 0, 0,           "ext_p");
        add_vec(0, 0,      0,      0, 1, 1073741824,  "ext_result");
        add_vec(0, 0,      0,      0, 1, 1073741824,  "ext_hold");

        repeat (2) @(posedge clk);
        #1;
        check_output("reset_state", 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
        end

        // Async reset mid-sum with a product still in flight.
        clr_cycle(0, "rst_clr");
        pair_cycle(25, 20, 0, 0, "rst_p1");
        pair_cycle(1, 1, 1, 500, "rst_pre");
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rst_async", 0, 0);
        @(negedge clk);
        en = 1'b1;
        a  = 16'sd3;
        b  = 16'sd3;
        @(posedge clk);
        #1;
        check_output("rst_held", 0, 0);
        @(negedge clk);
        en    = 1'b0;
        rst_n = 1'b1;
        idle_cycle(1, 0, "rst_after1");
        idle_cycle(1, 0, "rst_after2");
        pair_cycle(6, 7, 1, 0, "rst_new_p");
        idle_cycle(1, 42, "rst_new_land");
        idle_cycle(1, 42, "rst_new_hold");

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
